latch_wr_sequencer: RTL and testbench

- Synchronous writer that drives a bank of DEPTH level-sensitive latch words, each with d/en/clr/pre inputs.
- Accepts one request at a time and sequences it with guaranteed data setup, enable pulse width and data hold, so latch inputs never change while a latch is transparent.
- Serves as the clocked front end for latch-inference test designs in the QLF flow.

---
 rtl/latch_wr_sequencer.sv | 171 +++++++++++++++++
 tb/tb_latch_wr_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/latch_wr_sequencer.sv
// Clocked writer for a bank of level-sensitive latch words: sequences data setup,
// strobe pulse and data hold so latch inputs never move while a latch is open.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// S_IDLE   | req_ready high, waiting for a request
// S_SETUP  | lat_d driven, all strobes inactive, SETUP cycles
// S_STROBE | selected en/clr/pre strobe active, PULSE cycles
// S_HOLD   | strobes inactive, lat_d held, HOLD cycles; done on the last one
module latch_wr_sequencer #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int SETUP  = 1,
  parameter int PULSE  = 1,
  parameter int HOLD   = 1,
  parameter bit EN_POL = 1'b1,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [AW-1:0]    req_addr,
  input  logic [WIDTH-1:0] req_data,
  output logic [WIDTH-1:0] lat_d,
  output logic [DEPTH-1:0] lat_en,
  output logic [DEPTH-1:0] lat_clr,
  output logic [DEPTH-1:0] lat_pre,
  output logic             done,
  output logic             err
);

  if (WIDTH < 1 || DEPTH < 1 || SETUP < 0 || SETUP > 15 || PULSE < 1 || PULSE > 15 ||
      HOLD < 0 || HOLD > 15) begin : g_bad_params
    $error("latch_wr_sequencer: parameter out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

  localparam logic [DEPTH-1:0] EN_OFF   = {DEPTH{~EN_POL}};
  localparam logic [3:0]       SETUP_LD = 4'(SETUP - 1);
  localparam logic [3:0]       PULSE_LD = 4'(PULSE - 1);
  localparam logic [3:0]       HOLD_LD  = 4'(HOLD - 1);
  localparam bit               DONE_AT_ENTRY = (PULSE == 1) && (HOLD == 0);

  state_t          state;
  logic [3:0]      cnt;
  logic [1:0]      op_q;
  logic [AW-1:0]   addr_q;

  logic [1:0]       op_sel;
  logic [AW-1:0]    addr_sel;
  logic             oor_sel;
  logic [DEPTH-1:0] hit, en_act, clr_act, pre_act;

  // In IDLE the strobe pattern is decoded from the live request so that a
  // zero-length setup can assert the strobe on the cycle right after acceptance.
  always_comb begin
    op_sel   = (state == S_IDLE) ? req_op : op_q;
    addr_sel = (state == S_IDLE) ? req_addr : addr_q;
    oor_sel  = (op_sel != 2'b11) && (32'(addr_sel) >= DEPTH);
    hit      = '0;
    for (int i = 0; i < DEPTH; i++) hit[i] = (addr_sel == AW'(i)) && !oor_sel;
    en_act   = EN_OFF;
    clr_act  = '0;
    pre_act  = '0;
    case (op_sel)
      2'b00:   en_act  = EN_OFF ^ hit;
      2'b01:   clr_act = hit;
      2'b10:   pre_act = hit;
      default: clr_act = '1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      op_q      <= '0;
      addr_q    <= '0;
      lat_d     <= '0;
      lat_en    <= EN_OFF;
      lat_clr   <= '0;
      lat_pre   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            op_q      <= req_op;
            addr_q    <= req_addr;
            req_ready <= 1'b0;
            if (req_op == 2'b00) lat_d <= req_data;
            if (SETUP > 0) begin
              state <= S_SETUP;
              cnt   <= SETUP_LD;
            end else begin
              state   <= S_STROBE;
              cnt     <= PULSE_LD;
              lat_en  <= en_act;
              lat_clr <= clr_act;
              lat_pre <= pre_act;
              if (DONE_AT_ENTRY) begin
                done <= 1'b1;
                err  <= oor_sel;
              end
            end
          end
        end
        S_SETUP: begin
          if (cnt == 4'd0) begin
            state   <= S_STROBE;
            cnt     <= PULSE_LD;
            lat_en  <= en_act;
            lat_clr <= clr_act;
            lat_pre <= pre_act;
            if (DONE_AT_ENTRY) begin
              done <= 1'b1;
              err  <= oor_sel;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_STROBE: begin
          if (cnt == 4'd0) begin
            lat_en  <= EN_OFF;
            lat_clr <= '0;
            lat_pre <= '0;
            if (HOLD > 0) begin
              state <= S_HOLD;
              cnt   <= HOLD_LD;
              if (HOLD == 1) begin
                done <= 1'b1;
                err  <= oor_sel;
              end
            end else begin
              state     <= S_IDLE;
              req_ready <= 1'b1;
            end
          end else begin
            cnt <= cnt - 4'd1;
            // With no hold phase, done lands on the final strobe cycle.
            if (HOLD == 0 && cnt == 4'd1) begin
              done <= 1'b1;
              err  <= oor_sel;
            end
          end
        end
        default: begin
          if (cnt == 4'd0) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              done <= 1'b1;
              err  <= oor_sel;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_latch_wr_sequencer.sv
// Scoreboard bench for latch_wr_sequencer: three instances with different
// parameter sets; a monitor per instance accumulates strobe activity and pops on done.
module tb_latch_wr_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit         err;
    logic [3:0] en;
    logic [3:0] clr;
    logic [3:0] pre;
    int         nstb;
    int         lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  logic [2:0]       rv = '0;
  logic [2:0][1:0]  rop = '0;
  logic [2:0][1:0]  radr = '0;
  logic [2:0][7:0]  rdat = '0;
  logic [2:0]       rdy, dn, er;
  logic [2:0][7:0]  ld;
  logic [2:0][3:0]  en, clr, pre;

  assign en[2][3]  = 1'b0;
  assign clr[2][3] = 1'b0;
  assign pre[2][3] = 1'b0;

  // u0: defaults; u1: active-low enable, no setup/hold, 3-cycle pulse; u2: DEPTH=3
  latch_wr_sequencer #(.WIDTH(8), .DEPTH(4), .SETUP(1), .PULSE(1), .HOLD(1), .EN_POL(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv[0]), .req_ready(rdy[0]), .req_op(rop[0]),
    .req_addr(radr[0]), .req_data(rdat[0]), .lat_d(ld[0]), .lat_en(en[0]),
    .lat_clr(clr[0]), .lat_pre(pre[0]), .done(dn[0]), .err(er[0]));

  latch_wr_sequencer #(.WIDTH(8), .DEPTH(4), .SETUP(0), .PULSE(3), .HOLD(0), .EN_POL(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv[1]), .req_ready(rdy[1]), .req_op(rop[1]),
    .req_addr(radr[1]), .req_data(rdat[1]), .lat_d(ld[1]), .lat_en(en[1]),
    .lat_clr(clr[1]), .lat_pre(pre[1]), .done(dn[1]), .err(er[1]));

  latch_wr_sequencer #(.WIDTH(8), .DEPTH(3), .SETUP(1), .PULSE(1), .HOLD(1), .EN_POL(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv[2]), .req_ready(rdy[2]), .req_op(rop[2]),
    .req_addr(radr[2]), .req_data(rdat[2]), .lat_d(ld[2]), .lat_en(en[2][2:0]),
    .lat_clr(clr[2][2:0]), .lat_pre(pre[2][2:0]), .done(dn[2]), .err(er[2]));

  function automatic logic [3:0] en_off(int d);
    return (d == 1) ? 4'hF : 4'h0;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- monitor ----------------
  int         mcyc[3];
  int         mstb[3];
  logic [3:0] aen[3], aclr[3], apre[3];

  always @(negedge clk) begin
    logic [3:0] ea;
    int         ntypes;
    exp_t       e;
    bit         have;
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        mcyc[d] = 0; mstb[d] = 0; aen[d] = '0; aclr[d] = '0; apre[d] = '0;
      end else begin
        chk($sformatf("err_without_done%0d", d), {31'd0, er[d] & ~dn[d]}, 32'd0);
        if (rdy[d]) begin
          chk($sformatf("done_while_idle%0d", d), {31'd0, dn[d]}, 32'd0);
          mcyc[d] = 0; mstb[d] = 0; aen[d] = '0; aclr[d] = '0; apre[d] = '0;
        end else begin
          mcyc[d]++;
          ea = en[d] ^ en_off(d);
          ntypes = int'(ea != 0) + int'(clr[d] != 0) + int'(pre[d] != 0);
          chk($sformatf("one_strobe_type%0d", d), {31'd0, ntypes <= 1}, 32'd1);
          aen[d] |= ea; aclr[d] |= clr[d]; apre[d] |= pre[d];
          if (ntypes != 0) mstb[d]++;
          if (dn[d]) begin
            have = 1'b0;
            case (d)
              0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
              1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
              default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
            endcase
            chk($sformatf("done_expected%0d", d), {31'd0, have}, 32'd1);
            if (have) begin
              chk($sformatf("sb_err%0d", d), {31'd0, er[d]}, {31'd0, e.err});
              chk($sformatf("sb_en%0d", d), {28'd0, aen[d]}, {28'd0, e.en});
              chk($sformatf("sb_clr%0d", d), {28'd0, aclr[d]}, {28'd0, e.clr});
              chk($sformatf("sb_pre%0d", d), {28'd0, apre[d]}, {28'd0, e.pre});
              chk($sformatf("sb_strobe_cycles%0d", d), mstb[d], e.nstb);
              chk($sformatf("sb_latency%0d", d), mcyc[d], e.lat);
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic push(int d, bit e_err, logic [3:0] e_en, logic [3:0] e_clr,
                      logic [3:0] e_pre, int nstb, int lat);
    exp_t e;
    e.err = e_err; e.en = e_en; e.clr = e_clr; e.pre = e_pre; e.nstb = nstb; e.lat = lat;
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic send(int d, logic [1:0] op, logic [1:0] a, logic [7:0] dat, bit keep,
                      output time acc_t);
    int n;
    @(negedge clk);
    rv[d] = 1'b1; rop[d] = op; radr[d] = a; rdat[d] = dat;
    n = 0;
    while (!rdy[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("ready_wait%0d", d), {31'd0, n < 50}, 32'd1);
    @(posedge clk);
    acc_t = $time;
    #1;
    if (!keep) rv[d] = 1'b0;
  endtask

  initial begin
    time t1, t2;

    #2 rst_n = 1'b0;
    #10;
    chk("rst_en0", {28'd0, en[0]}, 32'h0);
    chk("rst_en1_actlow", {28'd0, en[1]}, 32'hF);
    chk("rst_clr0", {28'd0, clr[0]}, 32'h0);
    chk("rst_pre0", {28'd0, pre[0]}, 32'h0);
    chk("rst_d0", {24'd0, ld[0]}, 32'h0);
    chk("rst_done0", {31'd0, dn[0]}, 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready0", {31'd0, rdy[0]}, 32'd1);
    chk("rst_ready1", {31'd0, rdy[1]}, 32'd1);
    chk("rst_ready2", {31'd0, rdy[2]}, 32'd1);

    // write A5 to word 2: setup, 1-cycle enable, hold, done at cycle 3
    push(0, 1'b0, 4'b0100, 4'b0000, 4'b0000, 1, 3);
    send(0, 2'b00, 2'd2, 8'hA5, 1'b0, t1);
    @(negedge clk);
    chk("wr_setup_d", {24'd0, ld[0]}, 32'hA5);
    chk("wr_setup_en", {28'd0, en[0]}, 32'h0);
    chk("wr_setup_ready", {31'd0, rdy[0]}, 32'd0);
    @(negedge clk);
    chk("wr_strobe_en", {28'd0, en[0]}, 32'b0100);
    chk("wr_strobe_d", {24'd0, ld[0]}, 32'hA5);
    chk("wr_strobe_ready", {31'd0, rdy[0]}, 32'd0);
    @(negedge clk);
    chk("wr_hold_en", {28'd0, en[0]}, 32'h0);
    chk("wr_hold_d", {24'd0, ld[0]}, 32'hA5);
    chk("wr_done", {31'd0, dn[0]}, 32'd1);
    chk("wr_hold_ready", {31'd0, rdy[0]}, 32'd0);
    @(negedge clk);
    chk("wr_ready_back", {31'd0, rdy[0]}, 32'd1);
    chk("wr_done_pulse", {31'd0, dn[0]}, 32'd0);

    // clear word 1 then preset word 3, valid held high across both
    push(0, 1'b0, 4'b0000, 4'b0010, 4'b0000, 1, 3);
    push(0, 1'b0, 4'b0000, 4'b0000, 4'b1000, 1, 3);
    send(0, 2'b01, 2'd1, 8'h11, 1'b1, t1);
    send(0, 2'b10, 2'd3, 8'h22, 1'b0, t2);
    chk("b2b_accept_gap", 32'(t2 - t1), 32'd40);
    repeat (4) @(negedge clk);
    chk("b2b_d_kept", {24'd0, ld[0]}, 32'hA5);
    chk("b2b_ready_back", {31'd0, rdy[0]}, 32'd1);

    // clear-all, no setup/hold, 3-cycle pulse, active-low enables stay high
    push(1, 1'b0, 4'b0000, 4'b1111, 4'b0000, 3, 3);
    send(1, 2'b11, 2'd2, 8'h00, 1'b0, t1);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk($sformatf("clrall_clr_c%0d", i), {28'd0, clr[1]}, 32'hF);
      chk($sformatf("clrall_en_c%0d", i), {28'd0, en[1]}, 32'hF);
      chk($sformatf("clrall_done_c%0d", i), {31'd0, dn[1]}, {31'd0, i == 3});
    end
    @(negedge clk);
    chk("clrall_clr_off", {28'd0, clr[1]}, 32'h0);
    chk("clrall_ready_back", {31'd0, rdy[1]}, 32'd1);

    // DEPTH=3: address 3 out of range, then an in-range write
    push(2, 1'b1, 4'b0000, 4'b0000, 4'b0000, 0, 3);
    send(2, 2'b00, 2'd3, 8'h3C, 1'b0, t1);
    repeat (3) @(negedge clk);
    chk("oor_done", {31'd0, dn[2]}, 32'd1);
    chk("oor_err", {31'd0, er[2]}, 32'd1);
    chk("oor_d", {24'd0, ld[2]}, 32'h3C);
    push(2, 1'b0, 4'b0100, 4'b0000, 4'b0000, 1, 3);
    send(2, 2'b00, 2'd2, 8'h7E, 1'b0, t1);
    repeat (4) @(negedge clk);
    chk("d3_wr_d", {24'd0, ld[2]}, 32'h7E);

    // reset in the middle of a strobe to word 0
    send(0, 2'b00, 2'd0, 8'h5A, 1'b0, t1);
    @(negedge clk);
    @(negedge clk);
    chk("midrst_strobe_en", {28'd0, en[0]}, 32'b0001);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_en_async", {28'd0, en[0]}, 32'h0);
    chk("midrst_d_clear", {24'd0, ld[0]}, 32'h0);
    chk("midrst_no_done", {31'd0, dn[0]}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_ready", {31'd0, rdy[0]}, 32'd1);
    repeat (6) @(negedge clk);
    chk("midrst_en_idle", {28'd0, en[0]}, 32'h0);

    chk("q0_empty", q0.size(), 32'd0);
    chk("q1_empty", q1.size(), 32'd0);
    chk("q2_empty", q2.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

endmodule
